// File: rtl/codma_sched_pkg.sv
// Shared types for the CODMA task scheduler: FSM states, queue entry, error codes.
package codma_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_RUN,
    ST_ABORT,
    ST_DRAIN,
    ST_DONE
  } sched_state_t;

  // Requester id field is sized for the largest supported requester count (8).
  localparam int ID_FIELD_W = 3;

  typedef struct packed {
    logic [ID_FIELD_W-1:0] id;
    logic [31:0]           task_ptr;
    logic [31:0]           status_ptr;
  } sched_entry_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;
  localparam logic [1:0] ERR_NO_BUSY  = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/codma_task_scheduler_if.sv
// DMA control port between the scheduler (master) and the DMA engine (slave).
interface codma_task_scheduler_if;
  logic        start;
  logic        stop;
  logic [31:0] task_pointer;
  logic [31:0] status_pointer;
  logic        busy;
  logic        irq;

  modport master (output start, stop, task_pointer, status_pointer, input busy, irq);
  modport slave  (input start, stop, task_pointer, status_pointer, output busy, irq);
endinterface

// File: rtl/codma_sched_fifo.sv
// Task descriptor queue: push/pop in the same cycle, flush discards everything queued.
// The head is read asynchronously so the dispatcher can pop and latch in one cycle.
module codma_sched_fifo
  import codma_sched_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_i,
  input  sched_entry_t       push_data_i,
  input  logic               pop_i,
  output sched_entry_t       pop_data_o,
  input  logic               flush_i,
  output logic [LVL_W-1:0]   level_o
);

  sched_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic [PTR_W-1:0] wr_ptr_next;

  assign wr_ptr_next = push_i ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
  assign pop_data_o  = mem[rd_ptr_reg];
  assign level_o     = level_reg;

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem[wr_ptr_reg] <= push_data_i;
    end
  end

  // Pointer and level bookkeeping; flush snaps the read pointer to the write pointer.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      if (flush_i) begin
        rd_ptr_reg <= wr_ptr_next;
        level_reg  <= '0;
      end else begin
        if (pop_i) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        level_reg <= level_reg + LVL_W'(push_i) - LVL_W'(pop_i);
      end
    end
  end

endmodule

// File: rtl/codma_task_scheduler.sv
// CODMA task scheduler: round-robin intake from requesters into a queue, then
// one-at-a-time dispatch to the DMA engine with busy/irq tracking and timeout abort.
module codma_task_scheduler
  import codma_sched_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int FIFO_DEPTH     = 4,
  parameter  int BUSY_WAIT      = 16,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int ID_W           = $clog2(NUM_REQ),
  localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0][31:0]  req_task_ptr_i,
  input  logic [NUM_REQ-1:0][31:0]  req_status_ptr_i,
  input  logic                      flush_i,
  codma_task_scheduler_if.master    dma,
  output logic                      done_valid_o,
  output logic [ID_W-1:0]           done_id_o,
  output logic [1:0]                done_err_o,
  output logic [LVL_W-1:0]          queue_level_o,
  output logic                      idle_o
);

  localparam int CNT_W = $clog2(max_int(BUSY_WAIT, TIMEOUT_CYCLES)) + 1;

  sched_state_t     state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [ID_W-1:0]  rr_ptr_reg;
  logic [ID_W-1:0]  cur_id_reg;
  logic             start_reg;
  logic             stop_reg;
  logic [31:0]      task_ptr_reg;
  logic [31:0]      status_ptr_reg;
  logic             done_valid_reg;
  logic [ID_W-1:0]  done_id_reg;
  logic [1:0]       done_err_reg;

  logic [LVL_W-1:0] level;
  logic             can_accept;
  logic             grant_found;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  scan_idx;
  logic             push;
  logic             pop;
  sched_entry_t     push_entry;
  sched_entry_t     head;
  logic             unused_id_bits;

  function automatic logic [ID_W-1:0] rr_wrap(input int v);
    return ID_W'((v >= NUM_REQ) ? v - NUM_REQ : v);
  endfunction

  // Full test uses the registered level, so a same-cycle pop never frees a slot early.
  assign can_accept = (level < LVL_W'(FIFO_DEPTH)) && !flush_i;
  assign push       = can_accept && grant_found;
  assign pop        = (state_reg == ST_IDLE) && (level != '0);

  // Round-robin scan: first valid requester at or after the pointer wins.
  always_comb begin
    req_ready_o = '0;
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = rr_wrap(int'(rr_ptr_reg) + k);
      if (!grant_found && req_valid_i[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
    if (push) begin
      req_ready_o[grant_id] = 1'b1;
    end
  end

  always_comb begin
    push_entry            = '0;
    push_entry.id         = ID_FIELD_W'(grant_id);
    push_entry.task_ptr   = req_task_ptr_i[grant_id];
    push_entry.status_ptr = req_status_ptr_i[grant_id];
  end

  // Upper id bits are always zero when fewer than 8 requesters exist.
  assign unused_id_bits = ^head.id;

  codma_sched_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .pop_data_o  (head),
    .flush_i     (flush_i),
    .level_o     (level)
  );

  // Round-robin pointer moves past the winner after every accept.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rr_ptr_reg <= '0;
    end else if (push) begin
      rr_ptr_reg <= rr_wrap(int'(grant_id) + 1);
    end
  end

  // Dispatch FSM with registered DMA and completion outputs; counter restarts on every state entry.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      cur_id_reg     <= '0;
      start_reg      <= 1'b0;
      stop_reg       <= 1'b0;
      task_ptr_reg   <= '0;
      status_ptr_reg <= '0;
      done_valid_reg <= 1'b0;
      done_id_reg    <= '0;
      done_err_reg   <= '0;
    end else begin
      start_reg      <= 1'b0;
      stop_reg       <= 1'b0;
      done_valid_reg <= 1'b0;
      cnt_reg        <= (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            cnt_reg    <= '0;
            cur_id_reg <= head.id[ID_W-1:0];
            if (head.task_ptr[1:0] != 2'b00) begin
              state_reg      <= ST_DONE;
              done_valid_reg <= 1'b1;
              done_id_reg    <= head.id[ID_W-1:0];
              done_err_reg   <= ERR_MISALIGN;
            end else begin
              state_reg      <= ST_LAUNCH;
              start_reg      <= 1'b1;
              task_ptr_reg   <= head.task_ptr;
              status_ptr_reg <= head.status_ptr;
            end
          end
        end
        ST_LAUNCH: begin
          state_reg <= ST_WAIT_BUSY;
          cnt_reg   <= '0;
        end
        ST_WAIT_BUSY: begin
          if (dma.busy) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_W'(BUSY_WAIT - 1)) begin
            state_reg      <= ST_DONE;
            cnt_reg        <= '0;
            done_valid_reg <= 1'b1;
            done_id_reg    <= cur_id_reg;
            done_err_reg   <= ERR_NO_BUSY;
          end
        end
        ST_RUN: begin
          // Completion is checked first so an irq on the timeout cycle still reports success.
          if (dma.irq || !dma.busy) begin
            state_reg      <= ST_DONE;
            cnt_reg        <= '0;
            done_valid_reg <= 1'b1;
            done_id_reg    <= cur_id_reg;
            done_err_reg   <= ERR_OK;
          end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_reg <= ST_ABORT;
            cnt_reg   <= '0;
            stop_reg  <= 1'b1;
          end
        end
        ST_ABORT: begin
          state_reg <= ST_DRAIN;
          cnt_reg   <= '0;
        end
        ST_DRAIN: begin
          if (!dma.busy) begin
            state_reg      <= ST_DONE;
            cnt_reg        <= '0;
            done_valid_reg <= 1'b1;
            done_id_reg    <= cur_id_reg;
            done_err_reg   <= ERR_TIMEOUT;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign dma.start          = start_reg;
  assign dma.stop           = stop_reg;
  assign dma.task_pointer   = task_ptr_reg;
  assign dma.status_pointer = status_ptr_reg;
  assign done_valid_o       = done_valid_reg;
  assign done_id_o          = done_id_reg;
  assign done_err_o         = done_err_reg;
  assign queue_level_o      = level;
  assign idle_o             = (state_reg == ST_IDLE) && (level == '0);

endmodule

// File: tb/tb_codma_task_scheduler.sv
// Directed bench for codma_task_scheduler (TIMEOUT_CYCLES shortened to 32).
module tb_codma_task_scheduler;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [3:0][31:0]  req_task_ptr;
  logic [3:0][31:0]  req_status_ptr;
  logic              flush;
  logic              done_valid;
  logic [1:0]        done_id;
  logic [1:0]        done_err;
  logic [2:0]        queue_level;
  logic              idle;

  int n_cmp = 0;
  int n_mis = 0;
  int start_cnt = 0;
  int stop_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  codma_task_scheduler_if dma_if();

  codma_task_scheduler #(
    .NUM_REQ(4), .FIFO_DEPTH(4), .BUSY_WAIT(16), .TIMEOUT_CYCLES(32)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_task_ptr_i   (req_task_ptr),
    .req_status_ptr_i (req_status_ptr),
    .flush_i          (flush),
    .dma              (dma_if.master),
    .done_valid_o     (done_valid),
    .done_id_o        (done_id),
    .done_err_o       (done_err),
    .queue_level_o    (queue_level),
    .idle_o           (idle)
  );

  // Event counters and one line per completed task.
  always @(negedge clk) begin
    if (dma_if.start) start_cnt++;
    if (dma_if.stop)  stop_cnt++;
    if (done_valid) begin
      done_cnt++;
      $display("done: id=%0d err=%0d", done_id, done_err);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic evt(input int sel);
    case (sel)
      0:       return dma_if.start;
      1:       return dma_if.stop;
      default: return done_valid;
    endcase
  endfunction

  // Bounded wait for start (0), stop (1) or done (2); expiry counts as a failed comparison.
  task automatic wait_evt(input int sel, input string tag, input int max, output int waited);
    waited = 0;
    while (!evt(sel) && waited < max) begin
      step();
      waited++;
    end
    if (!evt(sel)) check_val({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int w;
    int s0;
    int d0;
    int p0;
    logic [3:0] exp_rdy [5];

    reset_n        = 1'b0;
    req_valid      = '0;
    req_task_ptr   = '0;
    req_status_ptr = '0;
    flush          = 1'b0;
    dma_if.busy    = 1'b0;
    dma_if.irq     = 1'b0;
    repeat (3) step();

    // Reset state
    check_val("rst_idle", idle, 1);
    check_val("rst_start", dma_if.start, 0);
    check_val("rst_stop", dma_if.stop, 0);
    check_val("rst_done", done_valid, 0);
    check_val("rst_level", queue_level, 0);
    check_val("rst_ready", req_ready, 0);
    check_val("rst_tptr", dma_if.task_pointer, 0);
    reset_n = 1'b1;
    step();

    // Single task from requester 0
    req_valid = 4'b0001; req_task_ptr[0] = 32'h1000; req_status_ptr[0] = 32'h2000;
    #1;
    check_val("t1_ready", req_ready, 4'b0001);
    s0 = start_cnt;
    step();
    req_valid = '0;
    check_val("t1_level", queue_level, 1);
    wait_evt(0, "t1_start", 10, w);
    check_val("t1_launch_lat", w, 1);
    check_val("t1_tptr", dma_if.task_pointer, 32'h1000);
    check_val("t1_sptr", dma_if.status_pointer, 32'h2000);
    repeat (3) step();
    dma_if.busy = 1'b1;
    repeat (10) step();
    dma_if.irq = 1'b1;
    step();
    dma_if.irq = 1'b0;
    check_val("t1_done", done_valid, 1);
    check_val("t1_id", done_id, 0);
    check_val("t1_err", done_err, 2'b00);
    check_val("t1_tptr_hold", dma_if.task_pointer, 32'h1000);
    dma_if.busy = 1'b0;
    step();
    check_val("t1_done_pulse", done_valid, 0);
    check_val("t1_idle", idle, 1);
    check_val("t1_nstart", start_cnt - s0, 1);

    // Misaligned task from requester 1: no start, done one cycle after pop
    req_valid = 4'b0010; req_task_ptr[1] = 32'h1002; req_status_ptr[1] = 32'h2100;
    #1;
    check_val("t2_ready", req_ready, 4'b0010);
    s0 = start_cnt;
    step();
    req_valid = '0;
    step();
    check_val("t2_done", done_valid, 1);
    check_val("t2_id", done_id, 1);
    check_val("t2_err", done_err, 2'b10);
    step();
    check_val("t2_nstart", start_cnt - s0, 0);
    check_val("t2_idle", idle, 1);

    // No busy from requester 2; stray irq in WAIT_BUSY is ignored
    req_valid = 4'b0100; req_task_ptr[2] = 32'h3000; req_status_ptr[2] = 32'h3100;
    #1;
    check_val("t3_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    step();
    check_val("t3_start", dma_if.start, 1);
    repeat (2) step();
    dma_if.irq = 1'b1;
    step();
    dma_if.irq = 1'b0;
    repeat (13) step();
    check_val("t3_not_early", done_valid, 0);
    step();
    check_val("t3_done", done_valid, 1);
    check_val("t3_id", done_id, 2);
    check_val("t3_err", done_err, 2'b11);
    step();

    // Timeout from requester 3: stop at RUN+32, busy drops 5 cycles later
    req_valid = 4'b1000; req_task_ptr[3] = 32'h4000; req_status_ptr[3] = 32'h4100;
    #1;
    check_val("t4_ready", req_ready, 4'b1000);
    p0 = stop_cnt;
    step();
    req_valid = '0;
    step();
    check_val("t4_start", dma_if.start, 1);
    dma_if.busy = 1'b1;
    repeat (33) step();
    check_val("t4_stop_not_early", dma_if.stop, 0);
    step();
    check_val("t4_stop", dma_if.stop, 1);
    check_val("t4_tptr", dma_if.task_pointer, 32'h4000);
    step();
    check_val("t4_stop_pulse", dma_if.stop, 0);
    repeat (4) step();
    dma_if.busy = 1'b0;
    step();
    check_val("t4_done", done_valid, 1);
    check_val("t4_id", done_id, 3);
    check_val("t4_err", done_err, 2'b01);
    check_val("t4_nstop", stop_cnt - p0, 1);
    step();

    // Fairness: all requesters valid, accept order 0,1,2,3,0, queue fills
    for (int i = 0; i < 4; i++) begin
      req_task_ptr[i]   = 32'h8000 + 32'(i) * 32'h100;
      req_status_ptr[i] = 32'h9000 + 32'(i) * 32'h100;
    end
    exp_rdy[0] = 4'b0001; exp_rdy[1] = 4'b0010; exp_rdy[2] = 4'b0100;
    exp_rdy[3] = 4'b1000; exp_rdy[4] = 4'b0001;
    req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("t5_accept%0d", i), req_ready, exp_rdy[i]);
      step();
    end
    check_val("t5_level_full", queue_level, 4);
    check_val("t5_ready_full", req_ready, 0);
    req_valid = '0;
    wait_evt(2, "t5_done0", 30, w);
    check_val("t5_id0", done_id, 0);
    check_val("t5_err0", done_err, 2'b11);

    // Flush with 3 queued + 1 in flight
    step();
    step();
    check_val("t6_start", dma_if.start, 1);
    check_val("t6_level", queue_level, 3);
    check_val("t6_tptr", dma_if.task_pointer, 32'h8100);
    flush = 1'b1; req_valid = 4'b0100;
    #1;
    check_val("t6_ready_flush", req_ready, 0);
    d0 = done_cnt;
    step();
    flush = 1'b0; req_valid = '0;
    check_val("t6_level_flushed", queue_level, 0);
    dma_if.busy = 1'b1;
    repeat (3) step();
    dma_if.irq = 1'b1;
    step();
    dma_if.irq = 1'b0;
    check_val("t6_done", done_valid, 1);
    check_val("t6_id", done_id, 1);
    check_val("t6_err", done_err, 2'b00);
    dma_if.busy = 1'b0;
    repeat (20) step();
    check_val("t6_ndone", done_cnt - d0, 1);
    check_val("t6_idle", idle, 1);

    // Reset while in RUN
    req_valid = 4'b0100; req_task_ptr[2] = 32'h5000; req_status_ptr[2] = 32'h5100;
    #1;
    check_val("t7_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    step();
    check_val("t7_start", dma_if.start, 1);
    dma_if.busy = 1'b1;
    repeat (5) step();
    reset_n = 1'b0;
    d0 = done_cnt;
    p0 = stop_cnt;
    step();
    check_val("t7_idle", idle, 1);
    check_val("t7_tptr", dma_if.task_pointer, 0);
    check_val("t7_sptr", dma_if.status_pointer, 0);
    check_val("t7_start0", dma_if.start, 0);
    check_val("t7_stop0", dma_if.stop, 0);
    check_val("t7_done0", done_valid, 0);
    check_val("t7_err0", done_err, 0);
    check_val("t7_level0", queue_level, 0);
    dma_if.busy = 1'b0;
    reset_n = 1'b1;
    repeat (3) step();
    check_val("t7_ndone", done_cnt - d0, 0);
    check_val("t7_nstop", stop_cnt - p0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
